// File: rtl/axi4_protocol_monitor.sv
// Passive AXI4 memory-slave protocol checker: one outstanding write and read burst,
// payload stability, beat/last, response decode and timeout checks, with error capture.
module axi4_protocol_monitor #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int RESP_TIMEOUT = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  AWVALID,
  input  logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WLAST,
  input  logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  input  logic                  RREADY,
  input  logic                  clear_errs,
  output logic [12:0]           err_pulse,
  output logic [12:0]           err_sticky,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [3:0]            first_err_id,
  output logic                  first_err_valid,
  output logic [CNT_WIDTH-1:0]  wr_done_cnt,
  output logic [CNT_WIDTH-1:0]  rd_done_cnt
);
  localparam int BSHIFT = $clog2(DATA_WIDTH / 8);
  localparam int TW     = $clog2(RESP_TIMEOUT + 2);
  localparam logic [TW-1:0] TO = TW'(RESP_TIMEOUT);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rst_t;

  function automatic logic [1:0] exp_resp(input logic [ADDR_WIDTH-1:0] addr,
                                          input logic [7:0] len, input logic [2:0] size);
    logic [31:0] a, span;
    a    = 32'(addr);
    span = (32'(len) + 32'd1) << size;
    if (((a & 32'hFFF) + span) > 32'd4096 || (a >> BSHIFT) >= 32'(MEM_DEPTH)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [3:0] lowest(input logic [12:0] v);
    logic [3:0] id;
    id = '0;
    for (int i = 12; i >= 0; i--) if (v[i]) id = 4'(i);
    return id;
  endfunction

  // Previous-cycle stall history and payload snapshots
  logic aw_stall_q, w_stall_q, b_stall_q, ar_stall_q, r_stall_q, bvld_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [7:0]            aw_len_q, ar_len_q;
  logic [2:0]            aw_size_q, ar_size_q;
  logic [DATA_WIDTH-1:0] w_data_q, r_data_q;
  logic                  w_last_q, r_last_q;
  logic [1:0]            b_resp_q, r_resp_q;

  wst_t wst_q, wst_d;
  rst_t rst_q, rst_d;
  logic [7:0] wlen_q, wlen_d, wbeat_q, wbeat_d, rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [1:0] wexp_q, wexp_d, rexp_q, rexp_d;
  logic [TW-1:0] wtim_q, wtim_d, rtim_q, rtim_d;
  logic [CNT_WIDTH-1:0] wdone_q, wdone_d, rdone_q, rdone_d, cnt_q, cnt_d;
  logic [12:0] pulse_q, pulse_d, sticky_q, sticky_d;
  logic [3:0]  fid_q, fid_d;
  logic        fv_q, fv_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_act;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;
  assign r_act = (rst_q == R_DATA) || (rst_q == R_WAIT && RVALID);

  always_comb begin
    pulse_d = '0;
    wst_d = wst_q; wlen_d = wlen_q; wbeat_d = wbeat_q; wexp_d = wexp_q; wtim_d = wtim_q;
    rst_d = rst_q; rlen_d = rlen_q; rbeat_d = rbeat_q; rexp_d = rexp_q; rtim_d = rtim_q;
    wdone_d = wdone_q; rdone_d = rdone_q;

    pulse_d[0] = aw_stall_q && (!AWVALID || AWADDR != aw_addr_q || AWLEN != aw_len_q ||
                                AWSIZE != aw_size_q);
    pulse_d[1] = w_stall_q && (!WVALID || WDATA != w_data_q || WLAST != w_last_q);
    pulse_d[4] = b_stall_q && (!BVALID || BRESP != b_resp_q);
    pulse_d[6] = ar_stall_q && (!ARVALID || ARADDR != ar_addr_q || ARLEN != ar_len_q ||
                                ARSIZE != ar_size_q);
    pulse_d[8] = r_stall_q && (!RVALID || RDATA != r_data_q || RRESP != r_resp_q ||
                               RLAST != r_last_q);
    pulse_d[3] = BVALID && !bvld_q && (wst_q != W_RESP);

    case (wst_q)
      W_IDLE: begin
        pulse_d[12] = w_hs;
        if (aw_hs) begin
          wst_d = W_DATA; wlen_d = AWLEN; wbeat_d = '0; wexp_d = exp_resp(AWADDR, AWLEN, AWSIZE);
        end
      end
      W_DATA: if (w_hs) begin
        pulse_d[2] = WLAST != (wbeat_q == wlen_q);
        if (WLAST || wbeat_q == wlen_q) begin
          wst_d = W_RESP; wtim_d = '0;
        end else begin
          wbeat_d = wbeat_q + 8'd1;
        end
      end
      W_RESP: begin
        pulse_d[12] = w_hs;
        if (b_hs) begin
          pulse_d[5] = BRESP != wexp_q;
          wdone_d = wdone_q + CNT_WIDTH'(1);
          wst_d = W_IDLE;
          // A new AW accepted alongside the response starts the next burst directly
          if (aw_hs) begin
            wst_d = W_DATA; wlen_d = AWLEN; wbeat_d = '0; wexp_d = exp_resp(AWADDR, AWLEN, AWSIZE);
          end
        end else if (!BVALID) begin
          pulse_d[11] = wtim_q == TO;
          if (wtim_q <= TO) wtim_d = wtim_q + TW'(1);
        end
      end
      default: wst_d = W_IDLE;
    endcase

    case (rst_q)
      R_IDLE: if (ar_hs) begin
        rst_d = R_WAIT; rlen_d = ARLEN; rbeat_d = '0; rtim_d = '0;
        rexp_d = exp_resp(ARADDR, ARLEN, ARSIZE);
      end
      R_WAIT: if (!RVALID) begin
        pulse_d[10] = rtim_q == TO;
        if (rtim_q <= TO) rtim_d = rtim_q + TW'(1);
      end
      R_DATA: ;
      default: rst_d = R_IDLE;
    endcase

    // First RVALID in R_WAIT is treated as a data-phase beat in the same cycle
    if (r_act) begin
      rst_d = R_DATA;
      if (r_hs) begin
        pulse_d[7] = RLAST != (rbeat_q == rlen_q);
        pulse_d[9] = RRESP != rexp_q;
        if (RLAST || rbeat_q == rlen_q) begin
          rst_d = R_IDLE;
          rdone_d = rdone_q + CNT_WIDTH'(1);
          if (ar_hs) begin
            rst_d = R_WAIT; rlen_d = ARLEN; rbeat_d = '0; rtim_d = '0;
            rexp_d = exp_resp(ARADDR, ARLEN, ARSIZE);
          end
        end else begin
          rbeat_d = rbeat_q + 8'd1;
        end
      end
    end

    // A violation coincident with clear_errs survives the clear
    sticky_d = clear_errs ? pulse_d : (sticky_q | pulse_d);
    if (clear_errs)      cnt_d = (|pulse_d) ? CNT_WIDTH'(1) : '0;
    else if ((|pulse_d) && cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
    else                 cnt_d = cnt_q;
    fid_d = clear_errs ? 4'd0 : fid_q;
    fv_d  = clear_errs ? 1'b0 : fv_q;
    if ((|pulse_d) && (clear_errs || !fv_q)) begin
      fid_d = lowest(pulse_d); fv_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_stall_q <= 1'b0; w_stall_q <= 1'b0; b_stall_q <= 1'b0;
      ar_stall_q <= 1'b0; r_stall_q <= 1'b0; bvld_q <= 1'b0;
      aw_addr_q <= '0; aw_len_q <= '0; aw_size_q <= '0;
      ar_addr_q <= '0; ar_len_q <= '0; ar_size_q <= '0;
      w_data_q <= '0; w_last_q <= 1'b0; b_resp_q <= '0;
      r_data_q <= '0; r_last_q <= 1'b0; r_resp_q <= '0;
      wst_q <= W_IDLE; wlen_q <= '0; wbeat_q <= '0; wexp_q <= '0; wtim_q <= '0;
      rst_q <= R_IDLE; rlen_q <= '0; rbeat_q <= '0; rexp_q <= '0; rtim_q <= '0;
      wdone_q <= '0; rdone_q <= '0; cnt_q <= '0;
      pulse_q <= '0; sticky_q <= '0; fid_q <= '0; fv_q <= 1'b0;
    end else begin
      aw_stall_q <= AWVALID && !AWREADY; w_stall_q <= WVALID && !WREADY;
      b_stall_q  <= BVALID && !BREADY;   ar_stall_q <= ARVALID && !ARREADY;
      r_stall_q  <= RVALID && !RREADY;   bvld_q <= BVALID;
      aw_addr_q <= AWADDR; aw_len_q <= AWLEN; aw_size_q <= AWSIZE;
      ar_addr_q <= ARADDR; ar_len_q <= ARLEN; ar_size_q <= ARSIZE;
      w_data_q <= WDATA; w_last_q <= WLAST; b_resp_q <= BRESP;
      r_data_q <= RDATA; r_last_q <= RLAST; r_resp_q <= RRESP;
      wst_q <= wst_d; wlen_q <= wlen_d; wbeat_q <= wbeat_d; wexp_q <= wexp_d; wtim_q <= wtim_d;
      rst_q <= rst_d; rlen_q <= rlen_d; rbeat_q <= rbeat_d; rexp_q <= rexp_d; rtim_q <= rtim_d;
      wdone_q <= wdone_d; rdone_q <= rdone_d; cnt_q <= cnt_d;
      pulse_q <= pulse_d; sticky_q <= sticky_d; fid_q <= fid_d; fv_q <= fv_d;
    end
  end

  assign err_pulse       = pulse_q;
  assign err_sticky      = sticky_q;
  assign err_count       = cnt_q;
  assign first_err_id    = fid_q;
  assign first_err_valid = fv_q;
  assign wr_done_cnt     = wdone_q;
  assign rd_done_cnt     = rdone_q;
endmodule

// File: tb/tb_axi4_protocol_monitor.sv
// Directed bench for axi4_protocol_monitor: stimulus pushes hand-computed expectations,
// a monitor process pops and compares one entry per clock.
module tb_axi4_protocol_monitor;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, clear_errs;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;
  logic [12:0] err_pulse, err_sticky;
  logic [7:0]  err_count, wr_done_cnt, rd_done_cnt;
  logic [3:0]  first_err_id;
  logic        first_err_valid;

  always #5 ACLK = ~ACLK;

  axi4_protocol_monitor dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .clear_errs(clear_errs), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_count(err_count), .first_err_id(first_err_id), .first_err_valid(first_err_valid),
    .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt)
  );

  typedef struct {
    logic [12:0] pulse;
    logic        full;
    logic [12:0] sticky;
    logic [7:0]  cnt, wd, rd;
    logic [3:0]  fid;
    logic        fv;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge ACLK) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("err_pulse", 32'(err_pulse), 32'(e.pulse));
      if (e.full) begin
        check("err_sticky", 32'(err_sticky), 32'(e.sticky));
        check("err_count", 32'(err_count), 32'(e.cnt));
        check("wr_done_cnt", 32'(wr_done_cnt), 32'(e.wd));
        check("rd_done_cnt", 32'(rd_done_cnt), 32'(e.rd));
        check("first_err_id", 32'(first_err_id), 32'(e.fid));
        check("first_err_valid", 32'(first_err_valid), 32'(e.fv));
      end
    end
  end

  task automatic tick(input logic [12:0] p);
    @(posedge ACLK);
    q.push_back('{pulse: p, full: 1'b0, sticky: '0, cnt: '0, wd: '0, rd: '0, fid: '0, fv: 1'b0});
    @(negedge ACLK);
  endtask

  task automatic tick_chk(input logic [12:0] p, input logic [12:0] st, input logic [7:0] c,
                          input logic [7:0] wd, input logic [7:0] rd, input logic [3:0] fid,
                          input logic fv);
    @(posedge ACLK);
    q.push_back('{pulse: p, full: 1'b1, sticky: st, cnt: c, wd: wd, rd: rd, fid: fid, fv: fv});
    @(negedge ACLK);
  endtask

  task automatic idle_all();
    AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; BVALID = 0; BREADY = 0;
    ARVALID = 0; ARREADY = 0; RVALID = 0; RREADY = 0; WLAST = 0; RLAST = 0;
    AWADDR = 0; AWLEN = 0; AWSIZE = 2; ARADDR = 0; ARLEN = 0; ARSIZE = 2;
    WDATA = 0; RDATA = 0; BRESP = 0; RRESP = 0; clear_errs = 0;
  endtask

  task automatic do_reset();
    ARESET = 1;
    tick_chk(13'h0, 13'h0, 8'd0, 8'd0, 8'd0, 4'd0, 1'b0);
    ARESET = 0;
  endtask

  task automatic aw(input logic [15:0] a, input logic [7:0] l, input logic [12:0] p);
    AWADDR = a; AWLEN = l; AWSIZE = 2; AWVALID = 1; AWREADY = 1;
    tick(p);
    AWVALID = 0; AWREADY = 0;
  endtask

  task automatic ar(input logic [15:0] a, input logic [7:0] l, input logic [12:0] p);
    ARADDR = a; ARLEN = l; ARSIZE = 2; ARVALID = 1; ARREADY = 1;
    tick(p);
    ARVALID = 0; ARREADY = 0;
  endtask

  task automatic wbeat(input logic [31:0] d, input logic last, input logic [12:0] p);
    WDATA = d; WLAST = last; WVALID = 1; WREADY = 1;
    tick(p);
    WVALID = 0; WREADY = 0; WLAST = 0;
  endtask

  task automatic bresp(input logic [1:0] r, input logic [12:0] p);
    BRESP = r; BVALID = 1; BREADY = 1;
    tick(p);
    BVALID = 0; BREADY = 0;
  endtask

  task automatic rbeat(input logic [31:0] d, input logic [1:0] r, input logic last,
                       input logic [12:0] p);
    RDATA = d; RRESP = r; RLAST = last; RVALID = 1; RREADY = 1;
    tick(p);
    RVALID = 0; RREADY = 0; RLAST = 0;
  endtask

  initial begin
    idle_all();
    do_reset();

    // Clean 4-beat write and read at 0x10
    aw(16'h0010, 8'd3, 13'h0);
    for (int i = 0; i < 4; i++) wbeat(32'hA000 + i, i == 3, 13'h0);
    bresp(2'b00, 13'h0);
    ar(16'h0010, 8'd3, 13'h0);
    for (int i = 0; i < 4; i++) rbeat(32'hB000 + i, 2'b00, i == 3, 13'h0);
    tick_chk(13'h0, 13'h0, 8'd0, 8'd1, 8'd1, 4'd0, 1'b0);

    // AW address changes while stalled
    AWLEN = 0; AWSIZE = 2; AWVALID = 1; AWREADY = 0; AWADDR = 16'h0010;
    tick(13'h0);
    AWADDR = 16'h0014;
    tick(13'h0001);
    AWREADY = 1;
    tick(13'h0);
    AWVALID = 0; AWREADY = 0;
    tick_chk(13'h0, 13'h0001, 8'd1, 8'd1, 8'd1, 4'd0, 1'b1);
    wbeat(32'h1, 1'b1, 13'h0);
    bresp(2'b00, 13'h0);

    // Early WLAST on beat 1 of a 4-beat burst
    aw(16'h0020, 8'd3, 13'h0);
    wbeat(32'h2, 1'b0, 13'h0);
    wbeat(32'h3, 1'b1, 13'h0004);
    bresp(2'b00, 13'h0);
    tick_chk(13'h0, 13'h0005, 8'd2, 8'd3, 8'd1, 4'd0, 1'b1);

    // 4KB crossing write and out-of-range read both expect SLVERR
    aw(16'h0FF0, 8'd7, 13'h0);
    for (int i = 0; i < 8; i++) wbeat(32'hC000 + i, i == 7, 13'h0);
    bresp(2'b00, 13'h0020);
    ar(16'h1000, 8'd0, 13'h0);
    rbeat(32'hD0, 2'b00, 1'b1, 13'h0200);
    tick_chk(13'h0, 13'h0225, 8'd4, 8'd4, 8'd2, 4'd0, 1'b1);

    // Unexpected W and unsolicited B while idle
    wbeat(32'h5, 1'b1, 13'h1000);
    bresp(2'b00, 13'h0008);
    tick_chk(13'h0, 13'h122D, 8'd6, 8'd4, 8'd2, 4'd0, 1'b1);

    // Read timeout fires exactly once, burst still completes
    do_reset();
    ar(16'h0040, 8'd1, 13'h0);
    for (int k = 0; k < 18; k++) tick(k == 16 ? 13'h0400 : 13'h0);
    rbeat(32'hE0, 2'b00, 1'b0, 13'h0);
    rbeat(32'hE1, 2'b00, 1'b1, 13'h0);
    tick_chk(13'h0, 13'h0400, 8'd1, 8'd0, 8'd1, 4'd10, 1'b1);

    // Counter saturation, then clear with coincident violation, then plain clear
    do_reset();
    ARLEN = 0; ARSIZE = 2; ARVALID = 1; ARREADY = 0; ARADDR = 0;
    tick(13'h0);
    for (int i = 1; i <= 300; i++) begin
      ARADDR = 16'(i * 4);
      if (i == 300) tick_chk(13'h0040, 13'h0040, 8'd255, 8'd0, 8'd0, 4'd6, 1'b1);
      else          tick(13'h0040);
    end
    ARADDR = 16'(301 * 4); clear_errs = 1;
    tick_chk(13'h0040, 13'h0040, 8'd1, 8'd0, 8'd0, 4'd6, 1'b1);
    ARREADY = 1;
    tick_chk(13'h0, 13'h0, 8'd0, 8'd0, 8'd0, 4'd0, 1'b0);
    ARVALID = 0; ARREADY = 0; clear_errs = 0;
    rbeat(32'hF0, 2'b00, 1'b1, 13'h0);
    tick_chk(13'h0, 13'h0, 8'd0, 8'd0, 8'd1, 4'd0, 1'b0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge ACLK);
    #2;
    if (q.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
